// File: rtl/lc3_mem_arbiter.sv
// Two-port req/ack arbiter in front of the single-port LC3 memory.
// A granted request is latched, driven for 1+WAIT_STATES cycles, then acked for one cycle.
module lc3_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int FIXED_PRI   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_r_w,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              gnt_b
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              last_gnt_q, last_gnt_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              pick_b_s;

  // Winner selection; on a tie round-robin favours the port not granted last.
  always_comb begin
    pick_b_s = 1'b0;
    if (a_req && b_req) begin
      pick_b_s = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt_q;
    end else begin
      pick_b_s = b_req;
    end
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Next-state logic: requester inputs are only looked at in IDLE.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          state_d    = S_ACCESS;
          wcnt_d     = 4'(WAIT_STATES);
          gnt_d      = pick_b_s;
          last_gnt_d = pick_b_s;
          we_d       = pick_b_s ? b_we    : a_we;
          addr_d     = pick_b_s ? b_addr  : a_addr;
          wdata_d    = pick_b_s ? b_wdata : a_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
        end else begin
          state_d = S_ACK;
          if (gnt_q) begin
            b_rdata_d = mem_dout;
          end else begin
            a_rdata_d = mem_dout;
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registers only, so no input reaches mem_* combinationally.
  always_comb begin
    mem_addr = addr_q;
    mem_din  = wdata_q;
    mem_en   = 1'b0;
    mem_r_w  = 1'b0;
    a_ack    = 1'b0;
    b_ack    = 1'b0;
    case (state_q)
      S_ACCESS: begin
        mem_en  = 1'b1;
        mem_r_w = (wcnt_q == 4'd0) ? we_q : 1'b0;
      end
      S_ACK: begin
        a_ack = ~gnt_q;
        b_ack = gnt_q;
      end
      default: begin
        mem_en  = 1'b0;
        mem_r_w = 1'b0;
      end
    endcase
    a_rdata = a_rdata_q;
    b_rdata = b_rdata_q;
    busy    = (state_q != S_IDLE);
    gnt_b   = gnt_q;
  end

endmodule
